// File: rtl/bp_me_lce_req_wormhole_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_me_lce_req_wormhole_arbiter_pkg
//  Description : Coherence-network wormhole header layout constants and the
//                small index helper shared by the LCE request link arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package bp_me_lce_req_wormhole_arbiter_pkg;

    // Default coherence-network wormhole geometry
    localparam int c_coh_noc_flit_width = 32;
    localparam int c_coh_noc_cord_width = 6;
    localparam int c_coh_noc_len_width  = 4;

    // Next index in a cyclic scan of n requesters
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_me_lce_req_wormhole_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : bp_me_lce_req_wormhole_arbiter_rr
//  Description : Combinational round-robin winner selection. The priority
//                pointer advances past the winner only when the winner is
//                consumed (i_yumi).
//  Revision    : 1.0  initial release
// ============================================================================
module bp_me_lce_req_wormhole_arbiter_rr
    import bp_me_lce_req_wormhole_arbiter_pkg::*;
#(
    parameter int num_lce_p = 2,
    localparam int c_idx_width = $clog2(num_lce_p)
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic [num_lce_p-1:0]   i_reqs,
    input  logic                   i_yumi,
    output logic [num_lce_p-1:0]   o_grants,
    output logic [c_idx_width-1:0] o_idx,
    output logic                   o_v
);

    logic [c_idx_width-1:0] r_ptr;
    logic [c_idx_width-1:0] w_cand;
    int                     w_sum;

    // Scan cyclically from the pointer and take the first valid requester
    always_comb begin
        o_grants = '0;
        o_idx    = '0;
        o_v      = 1'b0;
        w_sum    = 0;
        w_cand   = '0;
        for (int i = 0; i < num_lce_p; i++) begin
            w_sum = int'(r_ptr) + i;
            if (w_sum >= num_lce_p) begin
                w_sum = w_sum - num_lce_p;
            end
            w_cand = c_idx_width'(w_sum);
            if (!o_v && i_reqs[w_cand]) begin
                o_v   = 1'b1;
                o_idx = w_cand;
            end
        end
        o_grants[o_idx] = o_v;
    end

    // Move priority to the requester after the consumed winner
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_ptr <= '0;
        end else if (i_yumi && o_v) begin
            r_ptr <= c_idx_width'(rr_next(32'(o_idx), num_lce_p));
        end
    end

endmodule
`default_nettype wire

// File: rtl/bp_me_lce_req_wormhole_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : bp_me_lce_req_wormhole_arbiter
//  Description : Shares one LCE request injection link among num_lce_p
//                wormhole packet sources. Round-robin per packet; the grant is
//                locked from header to last flit so packets never interleave.
//  Revision    : 1.0  initial release
// ============================================================================
module bp_me_lce_req_wormhole_arbiter
    import bp_me_lce_req_wormhole_arbiter_pkg::*;
#(
    parameter int num_lce_p    = 2,
    parameter int flit_width_p = c_coh_noc_flit_width,
    parameter int cord_width_p = c_coh_noc_cord_width,
    parameter int len_width_p  = c_coh_noc_len_width
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_lce_p*flit_width_p-1:0] flit_i,
    input  logic [num_lce_p-1:0]              v_i,
    output logic [num_lce_p-1:0]              ready_and_o,
    output logic [flit_width_p-1:0]           link_data_o,
    output logic                              link_v_o,
    input  logic                              link_ready_and_i,
    output logic [num_lce_p-1:0]              grant_o,
    output logic                              busy_o
);

    localparam int c_idx_width = $clog2(num_lce_p);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    state_e                   r_state;
    logic [c_idx_width-1:0]   r_owner;
    logic [len_width_p-1:0]   r_cnt;

    logic [num_lce_p-1:0]     w_arb_grants;
    logic [c_idx_width-1:0]   w_arb_idx;
    logic                     w_arb_v;
    logic                     w_arb_yumi;
    logic [num_lce_p-1:0]     w_grant;
    logic                     w_link_v;
    logic [flit_width_p-1:0]  w_link_data;
    logic [len_width_p-1:0]   w_len;
    logic                     w_accept;

    bp_me_lce_req_wormhole_arbiter_rr #(
        .num_lce_p (num_lce_p)
    ) u_arb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_reqs    (v_i),
        .i_yumi    (w_arb_yumi),
        .o_grants  (w_arb_grants),
        .o_idx     (w_arb_idx),
        .o_v       (w_arb_v)
    );

    // Owner selection: fresh arbitration when idle, locked owner mid-packet
    always_comb begin
        w_grant  = '0;
        w_link_v = 1'b0;
        if (r_state == IDLE) begin
            w_grant  = w_arb_grants;
            w_link_v = w_arb_v;
        end else begin
            w_grant[r_owner] = 1'b1;
            w_link_v         = v_i[r_owner];
        end
    end

    // One-hot flit mux steered by the current grant
    always_comb begin
        w_link_data = '0;
        for (int k = 0; k < num_lce_p; k++) begin
            if (w_grant[k]) begin
                w_link_data = w_link_data | flit_i[k*flit_width_p +: flit_width_p];
            end
        end
    end

    assign w_accept   = w_link_v & link_ready_and_i;
    assign w_arb_yumi = w_accept & (r_state == IDLE);
    assign w_len      = w_link_data[cord_width_p +: len_width_p];

    // Handshake outputs are held low for the whole time reset is asserted
    assign link_data_o = w_link_data;
    assign link_v_o    = w_link_v & reset_n_i;
    assign grant_o     = w_grant & {num_lce_p{reset_n_i}};
    assign ready_and_o = w_grant & {num_lce_p{link_ready_and_i & reset_n_i}};
    assign busy_o      = (r_state == SEND) & reset_n_i;

    // Packet lock: header with a body locks the owner, last body flit releases
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
            r_owner <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && (w_len != '0)) begin
                        r_state <= SEND;
                        r_owner <= w_arb_idx;
                        r_cnt   <= w_len;
                    end
                end
                SEND: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == len_width_p'(1)) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
